// File: rtl/mem_stage_pkg.sv
// Bus layouts and load-extension bit positions shared by the memory stage and its helpers.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 87;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 38;

    localparam int EXT_LB  = 0;
    localparam int EXT_LBU = 1;
    localparam int EXT_LH  = 2;
    localparam int EXT_LHU = 3;

    typedef struct packed {
        logic [15:0] ext;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ws_bus_t;

    typedef struct packed {
        logic        fwd_we;
        logic [4:0]  fwd_dest;
        logic [31:0] fwd_data;
    } ds_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load byte-lane extraction and sign/zero extension; purely combinational.
// Half-word selection uses off[1] only, so misaligned halves are silently truncated.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  ext,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        if (ext[EXT_LB])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (ext[EXT_LBU])
            result = {24'h0, byte_sel};
        else if (ext[EXT_LH])
            result = {{16{half_sel[15]}}, half_sel};
        else if (ext[EXT_LHU])
            result = {16'h0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EXE bus, formats SRAM load data, feeds WB and decode forwarding.
// Latency 1 cycle; stalls while WB is not ready, holding the entry-cycle SRAM data in a local buffer.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    logic        ms_valid;
    logic        ms_ready_go;
    es_bus_t     bus_r;
    logic        first_cycle;
    logic [31:0] rdata_buf;
    logic        rdata_buf_valid;
    logic [31:0] mem_word;
    logic [31:0] load_result;
    logic [31:0] final_result;
    ws_bus_t     ws_bus;
    ds_bus_t     ds_bus;
    logic        unused_ext_bits;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid        <= 1'b0;
            bus_r           <= '0;
            first_cycle     <= 1'b0;
            rdata_buf       <= 32'h0;
            rdata_buf_valid <= 1'b0;
        end else begin
            if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid && ms_allowin)
                bus_r <= es_to_ms_bus;
            first_cycle <= es_to_ms_valid && ms_allowin;
            // The SRAM output is overwritten by the next EXE address, so capture it on a first-cycle stall.
            if (ms_to_ws_valid && ws_allowin) begin
                rdata_buf_valid <= 1'b0;
            end else if (ms_valid && first_cycle && bus_r.res_from_mem && !ws_allowin) begin
                rdata_buf       <= data_sram_rdata;
                rdata_buf_valid <= 1'b1;
            end
        end
    end

    assign mem_word = rdata_buf_valid ? rdata_buf : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .ext    (bus_r.ext[3:0]),
        .off    (bus_r.alu_result[1:0]),
        .word   (mem_word),
        .result (load_result)
    );

    assign final_result = bus_r.res_from_mem ? load_result : bus_r.alu_result;

    always_comb begin
        ws_bus = '0;
        if (ms_to_ws_valid) begin
            ws_bus.gr_we        = bus_r.gr_we;
            ws_bus.dest         = bus_r.dest;
            ws_bus.final_result = final_result;
            ws_bus.pc           = bus_r.pc;
        end
    end

    always_comb begin
        ds_bus = '0;
        if (ms_valid) begin
            ds_bus.fwd_we   = bus_r.gr_we && (bus_r.dest != 5'd0);
            ds_bus.fwd_dest = bus_r.dest;
            ds_bus.fwd_data = final_result;
        end
    end

    assign ms_to_ws_bus    = ws_bus;
    assign ms_to_ds_bus    = ds_bus;
    assign unused_ext_bits = ^bus_r.ext[15:4];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load formatting, stall data hold, ALU streaming and reset mid-stall.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [86:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_to_ds_bus;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary expected summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [86:0] es_bus(input logic [3:0] ext, input logic rfm, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {12'h0, ext, rfm, we, dest, alu, pc};
    endfunction

    function automatic logic [69:0] ws_exp(input logic we, input logic [4:0] dest,
                                           input logic [31:0] res, input logic [31:0] pc);
        return {we, dest, res, pc};
    endfunction

    // Present one instruction for a single edge; returns #1 after the edge that accepted it.
    task automatic issue(input logic [86:0] b);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [3:0] ext, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [4:0] dest,
                              input logic [31:0] pc, input logic [31:0] exp_res);
        issue(es_bus(ext, 1'b1, 1'b1, dest, alu, pc));
        data_sram_rdata = rdata;
        #1;
        chk({tag, "_vld"}, ms_to_ws_valid, 1'b1);
        chk({tag, "_bus"}, ms_to_ws_bus, ws_exp(1'b1, dest, exp_res, pc));
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", ms_to_ws_valid, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_ws_bus", ms_to_ws_bus, 70'h0);
        chk("rst_ds_bus", ms_to_ds_bus, 38'h0);
        reset = 1'b0;

        // Word and sub-word loads, streaming with WB always ready
        load_check("lw", 4'h0, 32'h0000_1000, 32'h8899_AABB, 5'd5, 32'h100, 32'h8899_AABB);
        chk("lw_fwd", ms_to_ds_bus, {1'b1, 5'd5, 32'h8899_AABB});
        load_check("lb", 4'h1, 32'h0000_1003, 32'h80FF_7F01, 5'd6, 32'h104, 32'hFFFF_FF80);
        load_check("lbu", 4'h2, 32'h0000_1003, 32'h80FF_7F01, 5'd6, 32'h108, 32'h0000_0080);
        load_check("lb_off1", 4'h1, 32'h0000_1001, 32'h80FF_7F01, 5'd6, 32'h10C, 32'h0000_007F);
        load_check("lh_off2", 4'h4, 32'h0000_1002, 32'h8001_1234, 5'd7, 32'h110, 32'hFFFF_8001);
        load_check("lhu_off2", 4'h8, 32'h0000_1002, 32'h8001_1234, 5'd7, 32'h114, 32'h0000_8001);
        load_check("lh_off0", 4'h4, 32'h0000_1000, 32'h8001_1234, 5'd7, 32'h118, 32'h0000_1234);
        load_check("lh_off3", 4'h4, 32'h0000_1003, 32'h8001_1234, 5'd7, 32'h11C, 32'hFFFF_8001);

        // Stalled load: WB busy for 3 cycles, SRAM data changes after the entry cycle
        issue(es_bus(4'h0, 1'b1, 1'b1, 5'd7, 32'h2000, 32'h200));
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h1122_3344;
        #1;
        chk("stall_allowin0", ms_allowin, 1'b0);
        chk("stall_ds0", ms_to_ds_bus, {1'b1, 5'd7, 32'h1122_3344});
        for (int i = 1; i < 3; i++) begin
            @(posedge clk);
            #1;
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            chk($sformatf("stall_allowin%0d", i), ms_allowin, 1'b0);
            chk($sformatf("stall_ds%0d", i), ms_to_ds_bus, {1'b1, 5'd7, 32'h1122_3344});
        end
        // Release the stall while a new load enters in the same cycle
        @(posedge clk);
        #1;
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(4'h0, 1'b1, 1'b1, 5'd8, 32'h2004, 32'h204);
        #1;
        chk("stall_out_bus", ms_to_ws_bus, ws_exp(1'b1, 5'd7, 32'h1122_3344, 32'h200));
        @(posedge clk);
        #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("reenter_bus", ms_to_ws_bus, ws_exp(1'b1, 5'd8, 32'hCAFE_F00D, 32'h204));
        @(posedge clk);
        #1;
        chk("bubble_vld", ms_to_ws_valid, 1'b0);
        chk("bubble_bus", ms_to_ws_bus, 70'h0);

        // Back-to-back ALU ops, one with dest=0
        es_to_ms_valid  = 1'b1;
        data_sram_rdata = 32'h5555_5555;
        es_to_ms_bus    = es_bus(4'h0, 1'b0, 1'b1, 5'd3, 32'h0000_000A, 32'h300);
        @(posedge clk);
        #1;
        es_to_ms_bus = es_bus(4'h0, 1'b0, 1'b1, 5'd0, 32'h0000_000B, 32'h304);
        #1;
        chk("alu_a_bus", ms_to_ws_bus, ws_exp(1'b1, 5'd3, 32'h0000_000A, 32'h300));
        chk("alu_a_fwd", ms_to_ds_bus, {1'b1, 5'd3, 32'h0000_000A});
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        #1;
        chk("alu_b_bus", ms_to_ws_bus, ws_exp(1'b1, 5'd0, 32'h0000_000B, 32'h304));
        chk("alu_b_fwd_dest0", ms_to_ds_bus, {1'b0, 5'd0, 32'h0000_000B});
        @(posedge clk);
        #1;
        chk("alu_bubble_bus", ms_to_ws_bus, 70'h0);
        chk("alu_bubble_ds", ms_to_ds_bus, 38'h0);

        // Reset during a stalled load, then a fresh load must see live SRAM data
        issue(es_bus(4'h0, 1'b1, 1'b1, 5'd9, 32'h3000, 32'h400));
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h5566_7788;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_stall_vld", ms_to_ws_valid, 1'b0);
        chk("rst_stall_allowin", ms_allowin, 1'b1);
        chk("rst_stall_bus", ms_to_ws_bus, 70'h0);
        ws_allowin = 1'b1;
        load_check("post_rst_lw", 4'h0, 32'h0000_3004, 32'h0BAD_F00D, 5'd10, 32'h408, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        chk("final_idle", ms_to_ws_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
